ring_fifo: RTL and testbench

RING_FIFO -- requirements
Module: ring_fifo

---
 rtl/fifo_pkg.sv | 12 +
 rtl/ring_fifo_mem.sv | 32 +++
 rtl/ring_fifo.sv | 136 +++++++++++++
 tb/tb_ring_fifo.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: overflow handling policy and drop-counter width.
package fifo_pkg;

  // Policy applied when a write arrives while the FIFO is full and no read frees a slot.
  typedef enum logic {
    DROP_NEW         = 1'b0,
    OVERWRITE_OLDEST = 1'b1
  } overflow_mode_e;

  localparam int unsigned DROP_COUNT_BITS = 16;

endpackage

// File: rtl/ring_fifo_mem.sv
// Ring FIFO storage array: one synchronous write port, one asynchronous read port.
// Ports:
//   clk        - write clock
//   write_en   - store write_data at write_addr on the rising edge
//   write_addr - write slot
//   write_data - word to store
//   read_addr  - read slot
//   read_data  - contents of read_addr (combinational)
module ring_fifo_mem #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned ADDRESS_BITS = 4
) (
  input  logic                    clk,
  input  logic                    write_en,
  input  logic [ADDRESS_BITS-1:0] write_addr,
  input  logic [DATA_BITS-1:0]    write_data,
  input  logic [ADDRESS_BITS-1:0] read_addr,
  output logic [DATA_BITS-1:0]    read_data
);

  logic [DATA_BITS-1:0] mem [2**ADDRESS_BITS];

  // Contents are deliberately not reset; the pointers guard against stale slots.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/ring_fifo.sv
// Single-clock first-word-fall-through ring FIFO with selectable overflow policy.
// Ports:
//   clk              - clock, all state changes on the rising edge
//   reset            - asynchronous active-low reset
//   in_write/in_data - write strobe and data
//   in_read          - consume the head word
//   in_flush         - synchronous clear of stored words (highest priority)
//   out_data         - head word, 0 when empty
//   out_valid        - FIFO non-empty
//   out_full         - count == DEPTH
//   out_almost_full  - count >= ALMOST_FULL_LEVEL
//   out_almost_empty - count <= ALMOST_EMPTY_LEVEL
//   out_count        - stored word count
//   out_overflow     - one-cycle pulse the cycle after an overflow edge
//   out_drop_count   - words lost to overflow since reset, saturating
module ring_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned    DATA_BITS          = 8,
  parameter int unsigned    ADDRESS_BITS       = 4,
  parameter overflow_mode_e OVERFLOW_MODE      = DROP_NEW,
  parameter int unsigned    ALMOST_FULL_LEVEL  = (2 ** ADDRESS_BITS) - 2,
  parameter int unsigned    ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_write,
  input  logic [DATA_BITS-1:0]       in_data,
  input  logic                       in_read,
  input  logic                       in_flush,
  output logic [DATA_BITS-1:0]       out_data,
  output logic                       out_valid,
  output logic                       out_full,
  output logic                       out_almost_full,
  output logic                       out_almost_empty,
  output logic [ADDRESS_BITS:0]      out_count,
  output logic                       out_overflow,
  output logic [DROP_COUNT_BITS-1:0] out_drop_count
);

  localparam int unsigned PTR_BITS = ADDRESS_BITS + 1;

  logic [PTR_BITS-1:0]        wr_ptr;
  logic [PTR_BITS-1:0]        rd_ptr;
  logic [PTR_BITS-1:0]        wr_ptr_next;
  logic [PTR_BITS-1:0]        rd_ptr_next;
  logic [PTR_BITS-1:0]        count;
  logic [DROP_COUNT_BITS-1:0] drop_count;
  logic [DROP_COUNT_BITS-1:0] drop_count_next;
  logic                       overflow;
  logic                       overflow_next;
  logic                       empty;
  logic                       full;
  logic                       do_read;
  logic                       mem_write;
  logic [DATA_BITS-1:0]       mem_data;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDRESS_BITS] != rd_ptr[ADDRESS_BITS]) &&
                 (wr_ptr[ADDRESS_BITS-1:0] == rd_ptr[ADDRESS_BITS-1:0]);
  assign count = wr_ptr - rd_ptr;

  // Status decoded straight from registered pointers: zero read latency.
  assign out_data         = empty ? '0 : mem_data;
  assign out_valid        = !empty;
  assign out_full         = full;
  assign out_count        = count;
  assign out_almost_full  = 32'(count) >= ALMOST_FULL_LEVEL;
  assign out_almost_empty = 32'(count) <= ALMOST_EMPTY_LEVEL;
  assign out_overflow     = overflow;
  assign out_drop_count   = drop_count;

  // Next-state: flush beats everything; a read on empty is ignored, so
  // read+write on empty simply stores the word.
  always_comb begin
    wr_ptr_next     = wr_ptr;
    rd_ptr_next     = rd_ptr;
    drop_count_next = drop_count;
    overflow_next   = 1'b0;
    mem_write       = 1'b0;
    do_read         = in_read && !empty;

    if (in_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else if (in_write && full && !do_read) begin
      overflow_next = 1'b1;
      if (drop_count != '1) begin
        drop_count_next = drop_count + DROP_COUNT_BITS'(1);
      end
      if (OVERFLOW_MODE == OVERWRITE_OLDEST) begin
        // Oldest slot is the one being written; advancing both keeps count at DEPTH.
        mem_write   = 1'b1;
        wr_ptr_next = wr_ptr + PTR_BITS'(1);
        rd_ptr_next = rd_ptr + PTR_BITS'(1);
      end
    end else begin
      if (in_write) begin
        mem_write   = 1'b1;
        wr_ptr_next = wr_ptr + PTR_BITS'(1);
      end
      if (do_read) begin
        rd_ptr_next = rd_ptr + PTR_BITS'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      drop_count <= drop_count_next;
      overflow   <= overflow_next;
    end
  end

  ring_fifo_mem #(
    .DATA_BITS    (DATA_BITS),
    .ADDRESS_BITS (ADDRESS_BITS)
  ) u_mem (
    .clk        (clk),
    .write_en   (mem_write && reset),
    .write_addr (wr_ptr[ADDRESS_BITS-1:0]),
    .write_data (in_data),
    .read_addr  (rd_ptr[ADDRESS_BITS-1:0]),
    .read_data  (mem_data)
  );

endmodule

// File: tb/tb_ring_fifo.sv
// Self-checking bench for ring_fifo: one DROP_NEW and one OVERWRITE_OLDEST
// instance driven by shared stimulus, each compared with a queue model.
module tb_ring_fifo;
  import fifo_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AFL   = 3;
  localparam int unsigned AEL   = 1;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       in_write = 1'b0;
  logic       in_read  = 1'b0;
  logic       in_flush = 1'b0;
  logic [7:0] in_data  = 8'h00;

  logic [7:0]  d_data,  o_data;
  logic        d_valid, o_valid;
  logic        d_full,  o_full;
  logic        d_af,    o_af;
  logic        d_ae,    o_ae;
  logic [2:0]  d_count, o_count;
  logic        d_ovf,   o_ovf;
  logic [15:0] d_drops, o_drops;

  logic [7:0] q_d[$];
  logic [7:0] q_o[$];
  int         drops_d = 0;
  int         drops_o = 0;
  bit         ovf_d   = 1'b0;
  bit         ovf_o   = 1'b0;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  ring_fifo #(
    .DATA_BITS(8), .ADDRESS_BITS(2), .OVERFLOW_MODE(DROP_NEW),
    .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)
  ) u_drop (
    .clk(clk), .reset(reset), .in_write(in_write), .in_data(in_data),
    .in_read(in_read), .in_flush(in_flush), .out_data(d_data),
    .out_valid(d_valid), .out_full(d_full), .out_almost_full(d_af),
    .out_almost_empty(d_ae), .out_count(d_count), .out_overflow(d_ovf),
    .out_drop_count(d_drops)
  );

  ring_fifo #(
    .DATA_BITS(8), .ADDRESS_BITS(2), .OVERFLOW_MODE(OVERWRITE_OLDEST),
    .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)
  ) u_ovw (
    .clk(clk), .reset(reset), .in_write(in_write), .in_data(in_data),
    .in_read(in_read), .in_flush(in_flush), .out_data(o_data),
    .out_valid(o_valid), .out_full(o_full), .out_almost_full(o_af),
    .out_almost_empty(o_ae), .out_count(o_count), .out_overflow(o_ovf),
    .out_drop_count(o_drops)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input string n, input logic [7:0] data, input logic valid,
                           input logic full, input logic af, input logic ae,
                           input logic [2:0] cnt, input logic ovf, input logic [15:0] drops,
                           input int sz, input logic [7:0] head, input bit eovf, input int edrops);
    check({n, ".count"},  32'(cnt),   32'(sz));
    check({n, ".valid"},  32'(valid), 32'(sz != 0));
    check({n, ".data"},   32'(data),  32'((sz != 0) ? head : 8'h00));
    check({n, ".full"},   32'(full),  32'(sz == DEPTH));
    check({n, ".afull"},  32'(af),    32'(sz >= AFL));
    check({n, ".aempty"}, 32'(ae),    32'(sz <= AEL));
    check({n, ".ovf"},    32'(ovf),   32'(eovf));
    check({n, ".drops"},  32'(drops), 32'(edrops));
  endtask

  task automatic check_all();
    check_dut("drop", d_data, d_valid, d_full, d_af, d_ae, d_count, d_ovf, d_drops,
              q_d.size(), (q_d.size() != 0) ? q_d[0] : 8'h00, ovf_d, drops_d);
    check_dut("ovw", o_data, o_valid, o_full, o_af, o_ae, o_count, o_ovf, o_drops,
              q_o.size(), (q_o.size() != 0) ? q_o[0] : 8'h00, ovf_o, drops_o);
  endtask

  // Behavioural model of one clock edge for both overflow policies.
  task automatic model_update(input bit w, input logic [7:0] d, input bit r, input bit f);
    bit rd_d;
    bit rd_o;
    ovf_d = 1'b0;
    ovf_o = 1'b0;
    if (f) begin
      q_d.delete();
      q_o.delete();
    end else begin
      rd_d = r && (q_d.size() != 0);
      if (w && q_d.size() == DEPTH && !rd_d) begin
        ovf_d = 1'b1;
        if (drops_d < 65535) drops_d++;
      end else begin
        if (rd_d) void'(q_d.pop_front());
        if (w) q_d.push_back(d);
      end

      rd_o = r && (q_o.size() != 0);
      if (w && q_o.size() == DEPTH && !rd_o) begin
        ovf_o = 1'b1;
        if (drops_o < 65535) drops_o++;
        void'(q_o.pop_front());
        q_o.push_back(d);
      end else begin
        if (rd_o) void'(q_o.pop_front());
        if (w) q_o.push_back(d);
      end
    end
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit f);
    @(negedge clk);
    in_write = w;
    in_data  = d;
    in_read  = r;
    in_flush = f;
    @(posedge clk);
    model_update(w, d, r, f);
    #1 check_all();
  endtask

  task automatic model_reset();
    q_d.delete();
    q_o.delete();
    drops_d = 0;
    drops_o = 0;
    ovf_d   = 1'b0;
    ovf_o   = 1'b0;
  endtask

  initial begin
    // Power-on reset, with a write held high that must not be accepted.
    #1 reset = 1'b0;
    in_write = 1'b1;
    in_data  = 8'hAA;
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    reset    = 1'b1;
    in_write = 1'b0;

    // Fill, then overflow by one word.
    for (int i = 0; i < 4; i++) step(1'b1, 8'((i + 1) * 17), 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Drain past empty.
    repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Full with concurrent read+write: wrap pointers, no overflow.
    for (int i = 0; i < 4; i++) step(1'b1, 8'((i + 1) * 17), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h66 + i), 1'b1, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Read+write on empty, then flush beating a write.
    step(1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b1, 8'h88, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-operation between edges.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    #2 reset = 1'b0;
    in_write = 1'b1;
    in_data  = 8'hAA;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    reset    = 1'b1;
    in_write = 1'b0;
    step(1'b1, 8'h99, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
